// File: rtl/convolution_coprocessor_seq.sv
// Sequencer/accumulator computing the full linear convolution Y = X * H from two buffers.
// Optional saturation of each result to DATA_WIDTH is enabled by defining CONV_SAT_EN.
module convolution_coprocessor_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int ACC_WIDTH  = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] x_len_i,
    input  logic [ADDR_WIDTH-1:0] h_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  x_rd_o,
    output logic [ADDR_WIDTH-1:0] x_addr_o,
    input  logic [DATA_WIDTH-1:0] x_data_i,
    output logic                  h_rd_o,
    output logic [ADDR_WIDTH-1:0] h_addr_o,
    input  logic [DATA_WIDTH-1:0] h_data_i,
    output logic                  y_wr_o,
    output logic [ADDR_WIDTH:0]   y_addr_o,
    output logic [DATA_WIDTH-1:0] y_data_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RD,
        S_MAC,
        S_WR,
        S_DONE
    } state_t;

`ifdef CONV_SAT_EN
    localparam int RES_IN_W = ACC_WIDTH;
`else
    localparam int RES_IN_W = DATA_WIDTH;
`endif

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]         n_len, m_len, j_cnt;
    logic [ADDR_WIDTH:0]           i_cnt, nm_sum;
    logic                          tap_ok, last_tap, last_out, zero_len, rd_en, wr_en;
    logic                          vld_p1;
    logic signed [2*DATA_WIDTH-1:0] prod_p1;
    logic signed [ACC_WIDTH-1:0]   acc_p1;

    function automatic logic [DATA_WIDTH-1:0] result_f(input logic signed [RES_IN_W-1:0] a);
`ifdef CONV_SAT_EN
        logic [ACC_WIDTH-DATA_WIDTH:0] top;
        top = a[ACC_WIDTH-1:DATA_WIDTH-1];
        if (top == '0 || top == '1)
            return a[DATA_WIDTH-1:0];
        else if (a[ACC_WIDTH-1])
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
        return a;
`endif
    endfunction

    // A tap is valid when k = i - j lies in [0, N); checked without forming a negative k.
    assign tap_ok   = (i_cnt >= {1'b0, j_cnt}) &&
                      (i_cnt < ({1'b0, j_cnt} + {1'b0, n_len}));
    assign nm_sum   = {1'b0, n_len} + {1'b0, m_len};
    assign last_tap = (j_cnt == m_len - ADDR_WIDTH'(1));
    assign last_out = (i_cnt == nm_sum - (ADDR_WIDTH+1)'(2));
    assign zero_len = (x_len_i == '0) || (h_len_i == '0);
    assign prod_p1  = (2*DATA_WIDTH)'($signed(x_data_i)) * (2*DATA_WIDTH)'($signed(h_data_i));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i) state_nxt = zero_len ? S_DONE : S_CLR;
            S_CLR:   state_nxt = S_RD;
            S_RD:    state_nxt = S_MAC;
            S_MAC:   state_nxt = last_tap ? S_WR : S_RD;
            S_WR:    state_nxt = last_out ? S_DONE : S_CLR;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from state and registered counters; idle values are all zero.
    always_comb begin
        rd_en    = (state == S_RD) && tap_ok;
        wr_en    = (state == S_WR);
        busy_o   = (state != S_IDLE);
        done_o   = (state == S_DONE);
        x_rd_o   = rd_en;
        h_rd_o   = rd_en;
        x_addr_o = '0;
        h_addr_o = '0;
        y_wr_o   = wr_en;
        y_addr_o = '0;
        y_data_o = '0;
        if (rd_en) begin
            x_addr_o = i_cnt[ADDR_WIDTH-1:0] - j_cnt;
            h_addr_o = j_cnt;
        end
        if (wr_en) begin
            y_addr_o = i_cnt;
            y_data_o = result_f(acc_p1[RES_IN_W-1:0]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            n_len  <= '0;
            m_len  <= '0;
            i_cnt  <= '0;
            j_cnt  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start_i) begin
                    n_len <= x_len_i;
                    m_len <= h_len_i;
                    i_cnt <= '0;
                end
                S_CLR:   j_cnt  <= '0;
                S_RD:    vld_p1 <= tap_ok;
                S_MAC:   j_cnt  <= j_cnt + ADDR_WIDTH'(1);
                S_WR:    i_cnt  <= i_cnt + (ADDR_WIDTH+1)'(1);
                default: ;
            endcase
        end
    end

    // Stage p1: buffer data returned for the tap issued in RD; accumulation wraps.
    always_ff @(posedge clk_i) begin
        if (state == S_CLR)
            acc_p1 <= '0;
        else if (state == S_MAC && vld_p1)
            acc_p1 <= acc_p1 + ACC_WIDTH'(prod_p1);
    end

endmodule

// File: tb/tb_convolution_coprocessor_seq.sv
// Self-checking bench for convolution_coprocessor_seq: directed table, busy/reset sequences, random runs.
module tb_convolution_coprocessor_seq;

    logic       clk, rst_n, start;
    logic [4:0] x_len, h_len;
    logic       busy, done, x_rd, h_rd, y_wr;
    logic [4:0] x_addr, h_addr;
    logic [7:0] x_data, h_data, y_data;
    logic [5:0] y_addr;

    convolution_coprocessor_seq dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .x_len_i(x_len), .h_len_i(h_len),
        .busy_o(busy), .done_o(done),
        .x_rd_o(x_rd), .x_addr_o(x_addr), .x_data_i(x_data),
        .h_rd_o(h_rd), .h_addr_o(h_addr), .h_data_i(h_data),
        .y_wr_o(y_wr), .y_addr_o(y_addr), .y_data_o(y_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] x_mem [32];
    logic [7:0] h_mem [32];
    int xs [32];
    int hs [32];

    // Buffers with one-cycle read latency; data is garbage when not read.
    always @(posedge clk) begin
        if (x_rd) x_data <= x_mem[x_addr]; else x_data <= 8'($urandom);
        if (h_rd) h_data <= h_mem[h_addr]; else h_data <= 8'($urandom);
    end

    int n_vec = 0;
    int n_miss = 0;

    int wr_cnt, rd_cnt, bad_rd, bad_busy, done_cyc;
    int cap_y [64];
    int cap_a [64];
    int cap_c [64];

    typedef struct packed {
        logic [4:0]      n;
        logic [4:0]      m;
        logic [3:0][7:0] x;
        logic [3:0][7:0] h;
        logic [3:0][7:0] y;
        logic [7:0]      done_cyc;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_y(int i, int n, int m);
        int s;
        logic signed [19:0] a;
        s = 0;
        for (int j = 0; j < m; j++)
            if (i - j >= 0 && i - j < n) s += xs[i-j] * hs[j];
        a = s[19:0];
        s = a;
`ifdef CONV_SAT_EN
        if (s > 127) s = 127;
        else if (s < -128) s = -128;
`endif
        return s & 255;
    endfunction

    task automatic load_mem();
        for (int k = 0; k < 32; k++) begin
            x_mem[k] = xs[k][7:0];
            h_mem[k] = hs[k][7:0];
        end
    endtask

    // Runs one convolution; repulse > 0 re-asserts start with other lengths at that cycle.
    task automatic run(input int n, input int m, input int repulse);
        int exp_wr;
        wr_cnt = 0; rd_cnt = 0; bad_rd = 0; bad_busy = 0; done_cyc = -1;
        load_mem();
        @(negedge clk);
        start = 1'b1; x_len = 5'(n); h_len = 5'(m);
        for (int c = 1; c <= 5000; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0; x_len = 5'($urandom); h_len = 5'($urandom);
            end
            if (c == repulse) begin
                start = 1'b1; x_len = 5'($urandom_range(1, 31)); h_len = 5'($urandom_range(1, 31));
            end
            if (c == repulse + 1) start = 1'b0;
            if (!busy) bad_busy++;
            if (x_rd) begin
                rd_cnt++;
                if (!h_rd || int'(x_addr) >= n || int'(h_addr) >= m) bad_rd++;
            end else if (h_rd) bad_rd++;
            if (y_wr) begin
                if (wr_cnt < 64) begin
                    cap_y[wr_cnt] = int'(y_data);
                    cap_a[wr_cnt] = int'(y_addr);
                    cap_c[wr_cnt] = c;
                end
                wr_cnt++;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
        if (done_cyc < 0) begin
            check("done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            check("busy_after_done", int'({busy, done}), 0);
        end
        exp_wr = (n == 0 || m == 0) ? 0 : n + m - 1;
        check("wr_count", wr_cnt, exp_wr);
        check("rd_count", rd_cnt, n * m);
        check("rd_port", bad_rd, 0);
        check("busy_during_run", bad_busy, 0);
        for (int k = 0; k < exp_wr && k < wr_cnt && k < 64; k++) begin
            check("wr_addr", cap_a[k], k);
            check("wr_cycle", cap_c[k], (k + 1) * (2 * m + 2));
        end
    endtask

    task automatic check_y_model(input int n, input int m);
        for (int k = 0; k < n + m - 1 && k < wr_cnt && k < 64; k++)
            check("y_model", cap_y[k], model_y(k, n, m));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; x_len = '0; h_len = '0;

        tbl[0].n = 3; tbl[0].m = 2;
        tbl[0].x = {8'd0, 8'd3, 8'd2, 8'd1};
        tbl[0].h = {8'd0, 8'd0, 8'd1, 8'd1};
        tbl[0].y = {8'd3, 8'd5, 8'd3, 8'd1};
        tbl[0].done_cyc = 25;
        tbl[1].n = 2; tbl[1].m = 1;
        tbl[1].x = {8'd0, 8'd0, 8'd3, 8'hFE};
        tbl[1].h = {8'd0, 8'd0, 8'd0, 8'd4};
        tbl[1].y = {8'd0, 8'd0, 8'h0C, 8'hF8};
        tbl[1].done_cyc = 9;
        tbl[2].n = 1; tbl[2].m = 1;
        tbl[2].x = {8'd0, 8'd0, 8'd0, 8'd100};
        tbl[2].h = {8'd0, 8'd0, 8'd0, 8'd2};
        tbl[2].done_cyc = 5;
        tbl[3].n = 1; tbl[3].m = 1;
        tbl[3].x = {8'd0, 8'd0, 8'd0, 8'h9C};
        tbl[3].h = {8'd0, 8'd0, 8'd0, 8'd2};
        tbl[3].done_cyc = 5;
`ifdef CONV_SAT_EN
        tbl[2].y = {8'd0, 8'd0, 8'd0, 8'h7F};
        tbl[3].y = {8'd0, 8'd0, 8'd0, 8'h80};
`else
        tbl[2].y = {8'd0, 8'd0, 8'd0, 8'hC8};
        tbl[3].y = {8'd0, 8'd0, 8'd0, 8'h38};
`endif
        tbl[4].n = 0; tbl[4].m = 3;
        tbl[4].x = {8'd0, 8'd0, 8'd0, 8'd5};
        tbl[4].h = {8'd0, 8'd1, 8'd2, 8'd3};
        tbl[4].y = '0;
        tbl[4].done_cyc = 1;

        repeat (2) @(negedge clk);
        check("reset_ctrl", int'({busy, done, x_rd, h_rd, y_wr}), 0);
        check("reset_addr", int'({x_addr, h_addr, y_addr}), 0);
        check("reset_data", int'(y_data), 0);
        rst_n = 1'b1;

        // Directed table
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < 32; k++) begin
                xs[k] = $urandom_range(0, 255) - 128;
                hs[k] = $urandom_range(0, 255) - 128;
            end
            for (int k = 0; k < 4; k++) begin
                xs[k] = int'($signed(tbl[t].x[k]));
                hs[k] = int'($signed(tbl[t].h[k]));
            end
            run(int'(tbl[t].n), int'(tbl[t].m), 0);
            check("tbl_done_cycle", done_cyc, int'(tbl[t].done_cyc));
            for (int k = 0; k < int'(tbl[t].n) + int'(tbl[t].m) - 1 && k < wr_cnt; k++)
                check("tbl_y", cap_y[k], int'(tbl[t].y[k]));
        end

        // Start re-pulsed while busy must not disturb the run
        for (int k = 0; k < 4; k++) begin
            xs[k] = int'($signed(tbl[0].x[k]));
            hs[k] = int'($signed(tbl[0].h[k]));
        end
        run(3, 2, 7);
        check("repulse_done_cycle", done_cyc, 25);
        for (int k = 0; k < 4 && k < wr_cnt; k++)
            check("repulse_y", cap_y[k], int'(tbl[0].y[k]));

        // Reset in the middle of a run
        @(negedge clk);
        start = 1'b1; x_len = 5'd3; h_len = 5'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_ctrl", int'({busy, done, x_rd, h_rd, y_wr}), 0);
        check("midreset_addr", int'({x_addr, h_addr, y_addr}), 0);
        @(negedge clk);
        check("midreset_held", int'({busy, y_wr, y_data}), 0);
        rst_n = 1'b1;

        // Randomized runs against the model, including the largest lengths
        for (int r = 0; r < 10; r++) begin
            int n, m;
            n = (r == 9) ? 31 : $urandom_range(1, 7);
            m = (r == 9) ? 31 : $urandom_range(1, 7);
            for (int k = 0; k < 32; k++) begin
                xs[k] = $urandom_range(0, 255) - 128;
                hs[k] = $urandom_range(0, 255) - 128;
            end
            run(n, m, 0);
            check("rand_done_cycle", done_cyc, (n + m - 1) * (2 * m + 2) + 1);
            check_y_model(n, m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
